counter_step_sequencer: RTL

- Controller that sequences a pair of WIDTH-bit step counters (a, b) which advance together at a fixed cycle period.
- Handles load of start values, start/stop control, step-count limiting and wrap-around.
- Sits between a control source (bench or top-level FSM) and the counter datapath.
- Turns a free-running "increment every N time units" behaviour into a controlled, bounded run.

---
 rtl/counter_step_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/counter_step_sequencer.sv
// counter_step_sequencer
// Sequences two WIDTH-bit step counters (a, b) that advance together once every
// TICK_DIV clock cycles during a controlled run. A run is started from IDLE, can be
// bounded by a latched step limit (0 = free-run) and can be aborted with stop.
// Every run ends with a single DONE cycle before control returns to IDLE.
//
// Optional feature macro: SATURATE_EN
//   defined   : a and b stop at 2^WIDTH-1 instead of wrapping; the extra output
//               sat flags that a counter was held (cleared by the next start or reset).
//   undefined : a and b wrap modulo 2^WIDTH; there is no sat port.
module counter_step_sequencer #(
    parameter int WIDTH    = 5,
    parameter int TICK_DIV = 10,
    parameter int A_INIT   = 10,
    parameter int B_INIT   = 20,
    parameter int LIM_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    input  logic [LIM_W-1:0] step_limit,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             tick,
    output logic             busy,
    output logic             done,
`ifdef SATURATE_EN
    output logic             sat,
`endif
    output logic [LIM_W-1:0] steps_done
);

    // Divider is wide enough for 0..TICK_DIV-1; keep at least one bit so that
    // TICK_DIV=1 (tick every cycle) still elaborates cleanly.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [WIDTH-1:0] A_RST    = WIDTH'(A_INIT);
    localparam logic [WIDTH-1:0] B_RST    = WIDTH'(B_INIT);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [LIM_W-1:0] LIM_ONE  = LIM_W'(1);
    localparam logic [LIM_W-1:0] LIM_ZERO = '0;

    // Controller states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_reg,  state_next;
    logic [DIV_W-1:0] div_reg,    div_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [LIM_W-1:0] steps_reg,  steps_next;
    logic [LIM_W-1:0] limit_reg,  limit_next;
`ifdef SATURATE_EN
    logic             sat_reg,    sat_next;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
`endif

    // Derived per-cycle conditions
    logic             step_fire;
    logic [LIM_W-1:0] steps_inc;
    logic [WIDTH-1:0] a_inc;
    logic [WIDTH-1:0] b_inc;
    logic             limit_hit;

    // The step happens on the edge that closes the last divider cycle of a period.
    assign step_fire = (state_reg == S_RUN) && (div_reg == DIV_LAST);
    assign steps_inc = steps_reg + LIM_ONE;
    // A zero limit means free-run; steps_done then simply wraps.
    assign limit_hit = (limit_reg != LIM_ZERO) && (steps_inc == limit_reg);

`ifdef SATURATE_EN
    assign a_inc = (a_reg == CNT_MAX) ? CNT_MAX : (a_reg + CNT_ONE);
    assign b_inc = (b_reg == CNT_MAX) ? CNT_MAX : (b_reg + CNT_ONE);
`else
    assign a_inc = a_reg + CNT_ONE;
    assign b_inc = b_reg + CNT_ONE;
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        steps_next = steps_reg;
        limit_next = limit_reg;
`ifdef SATURATE_EN
        sat_next   = sat_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // Load is applied even when a run starts on the same edge, so the
                // run begins from the loaded values.
                if (load) begin
                    a_next = load_a;
                    b_next = load_b;
                end
                // Stop wins over start when both are asserted.
                if (start && !stop) begin
                    state_next = S_RUN;
                    limit_next = step_limit;
                    steps_next = LIM_ZERO;
                    div_next   = '0;
`ifdef SATURATE_EN
                    sat_next   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (step_fire) begin
                    a_next     = a_inc;
                    b_next     = b_inc;
                    steps_next = steps_inc;
                    div_next   = '0;
`ifdef SATURATE_EN
                    if ((a_reg == CNT_MAX) || (b_reg == CNT_MAX)) begin
                        sat_next = 1'b1;
                    end
`endif
                    if (limit_hit) begin
                        state_next = S_DONE;
                    end
                end else begin
                    div_next = div_reg + DIV_ONE;
                end
                // A step coinciding with stop is still taken above.
                if (stop) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            div_reg   <= '0;
            a_reg     <= A_RST;
            b_reg     <= B_RST;
            steps_reg <= LIM_ZERO;
            limit_reg <= LIM_ZERO;
`ifdef SATURATE_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            steps_reg <= steps_next;
            limit_reg <= limit_next;
`ifdef SATURATE_EN
            sat_reg   <= sat_next;
`endif
        end
    end

    assign a          = a_reg;
    assign b          = b_reg;
    assign steps_done = steps_reg;
    assign tick       = step_fire;
    assign busy       = (state_reg == S_RUN);
    assign done       = (state_reg == S_DONE);
`ifdef SATURATE_EN
    assign sat        = sat_reg;
`endif

endmodule
